// File: rtl/fifo_wr_ptr_ctrl_if.sv
// Write-side handshake bundle between the writer, the write-pointer controller and the read domain.
// The controller connects through the slave modport; the writer uses the master modport.
interface fifo_wr_ptr_ctrl_if #(
    parameter int unsigned ADDR_WIDTH = 4
);
    logic                  WEN_A;
    logic                  CLR_OVF;
    logic [ADDR_WIDTH:0]   R_PTR_GREY_ASYNC;
    logic [ADDR_WIDTH-1:0] W_ADDR_A;
    logic                  WR_ACCEPT;
    logic [ADDR_WIDTH:0]   W_PTR_GREY;
    logic                  FULL;
    logic                  ALMOST_FULL;
    logic [ADDR_WIDTH:0]   W_LEVEL;
    logic                  OVERFLOW;

    modport master (
        output WEN_A, CLR_OVF, R_PTR_GREY_ASYNC,
        input  W_ADDR_A, WR_ACCEPT, W_PTR_GREY, FULL, ALMOST_FULL, W_LEVEL, OVERFLOW
    );

    modport slave (
        input  WEN_A, CLR_OVF, R_PTR_GREY_ASYNC,
        output W_ADDR_A, WR_ACCEPT, W_PTR_GREY, FULL, ALMOST_FULL, W_LEVEL, OVERFLOW
    );
endinterface

// File: rtl/fifo_wr_ptr_ctrl.sv
// Write-side pointer controller of a dual-clock FIFO: owns the write pointer, exports it in gray
// code and derives FULL / ALMOST_FULL / level from the synchronised read pointer.
module fifo_wr_ptr_ctrl #(
    parameter int unsigned ADDR_WIDTH   = 4,
    parameter int unsigned AFULL_THRESH = 2**ADDR_WIDTH - 2,
    parameter int unsigned SYNC_STAGES  = 2
) (
    input  logic                CLK_A,
    input  logic                RST_N,
    fifo_wr_ptr_ctrl_if.slave   bus
);
    localparam int unsigned AW = ADDR_WIDTH;
    localparam logic [AW:0] AfullThr = (AW+1)'(AFULL_THRESH);

    logic [AW:0] wr_bin_q, wr_bin_d;
    logic [AW:0] wr_gray_q, wr_gray_d;
    logic [AW:0] sync_q [SYNC_STAGES];
    logic [AW:0] rd_gray_s, rd_bin_s;
    logic [AW:0] level_q, level_d;
    logic        full_q, full_d;
    logic        afull_q, afull_d;
    logic        ovf_q, ovf_d;
    logic        accept;

    function automatic logic [AW:0] bin2gray(input logic [AW:0] b);
        return b ^ (b >> 1);
    endfunction

    function automatic logic [AW:0] gray2bin(input logic [AW:0] g);
        logic [AW:0] b;
        b[AW] = g[AW];
        for (int i = int'(AW) - 1; i >= 0; i--) begin
            b[i] = b[i+1] ^ g[i];
        end
        return b;
    endfunction

    // Reset gates the accept so a request held through reset never reaches the RAM.
    assign accept    = bus.WEN_A & ~full_q & RST_N;
    assign rd_gray_s = sync_q[SYNC_STAGES-1];
    assign rd_bin_s  = gray2bin(rd_gray_s);

    always_comb begin
        wr_bin_d  = accept ? wr_bin_q + 1'b1 : wr_bin_q;
        wr_gray_d = bin2gray(wr_bin_d);
        level_d   = wr_bin_d - rd_bin_s;
        // Full when the pointers match except for the two top gray bits.
        full_d    = (wr_gray_d == {~rd_gray_s[AW:AW-1], rd_gray_s[AW-2:0]});
        afull_d   = (level_d >= AfullThr);
        ovf_d     = ovf_q;
        if (bus.WEN_A && full_q) begin
            ovf_d = 1'b1;
        end else if (bus.CLR_OVF) begin
            ovf_d = 1'b0;
        end
    end

    always_ff @(posedge CLK_A) begin
        if (!RST_N) begin
            wr_bin_q  <= '0;
            wr_gray_q <= '0;
            level_q   <= '0;
            full_q    <= 1'b0;
            afull_q   <= 1'b0;
            ovf_q     <= 1'b0;
            for (int i = 0; i < int'(SYNC_STAGES); i++) begin
                sync_q[i] <= '0;
            end
        end else begin
            wr_bin_q  <= wr_bin_d;
            wr_gray_q <= wr_gray_d;
            level_q   <= level_d;
            full_q    <= full_d;
            afull_q   <= afull_d;
            ovf_q     <= ovf_d;
            sync_q[0] <= bus.R_PTR_GREY_ASYNC;
            for (int i = 1; i < int'(SYNC_STAGES); i++) begin
                sync_q[i] <= sync_q[i-1];
            end
        end
    end

    assign bus.W_ADDR_A    = wr_bin_q[AW-1:0];
    assign bus.WR_ACCEPT   = accept;
    assign bus.W_PTR_GREY  = wr_gray_q;
    assign bus.FULL        = full_q;
    assign bus.ALMOST_FULL = afull_q;
    assign bus.W_LEVEL     = level_q;
    assign bus.OVERFLOW    = ovf_q;
endmodule

// File: tb/tb_fifo_wr_ptr_ctrl.sv
// Directed bench for fifo_wr_ptr_ctrl: table of reset/fill/overflow vectors plus hand-written
// drain, mid-fill reset and wrap-around sequences (ADDR_WIDTH=4, SYNC_STAGES=2).
module tb_fifo_wr_ptr_ctrl;
    logic clk = 1'b0;
    logic rst_n;
    int   n_checks = 0;
    int   n_fail   = 0;

    always #5 clk = ~clk;

    fifo_wr_ptr_ctrl_if #(.ADDR_WIDTH(4)) bus ();

    fifo_wr_ptr_ctrl #(
        .ADDR_WIDTH  (4),
        .AFULL_THRESH(14),
        .SYNC_STAGES (2)
    ) dut (
        .CLK_A(clk),
        .RST_N(rst_n),
        .bus  (bus.slave)
    );

    typedef struct {
        bit       rst_n;
        bit       wen;
        bit       clr;
        bit [4:0] rptr;
        bit       e_acc;
        bit [3:0] e_addr;
        bit [4:0] e_gray;
        bit       e_full;
        bit       e_afull;
        bit [4:0] e_level;
        bit       e_ovf;
    } vec_t;

    vec_t vecs[22];

    function automatic logic [4:0] g2(input int unsigned x);
        logic [4:0] b;
        b = 5'(x);
        return b ^ (b >> 1);
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic drive(input bit r, input bit w, input bit c, input logic [4:0] rp);
        rst_n                = r;
        bus.WEN_A            = w;
        bus.CLR_OVF          = c;
        bus.R_PTR_GREY_ASYNC = rp;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        int wraps;
        logic [3:0] prev_addr;
        logic [4:0] prev_gray;
        int unsigned rp_bin;

        // Reset with a pending write, then 16 writes filling the FIFO, then overflow handling.
        for (int i = 0; i < 22; i++) begin
            vecs[i] = '{rst_n: 1'b1, wen: 1'b1, clr: 1'b0, rptr: 5'd0, e_acc: 1'b0,
                        e_addr: 4'd0, e_gray: 5'd0, e_full: 1'b0, e_afull: 1'b0,
                        e_level: 5'd0, e_ovf: 1'b0};
        end
        vecs[0].rst_n = 1'b0;
        vecs[1].rst_n = 1'b0;
        for (int k = 1; k <= 16; k++) begin
            vecs[k+1].e_acc   = 1'b1;
            vecs[k+1].e_addr  = 4'(k);
            vecs[k+1].e_gray  = g2(k);
            vecs[k+1].e_full  = (k == 16);
            vecs[k+1].e_afull = (k >= 14);
            vecs[k+1].e_level = 5'(k);
        end
        for (int i = 18; i < 22; i++) begin
            vecs[i].e_gray  = 5'b11000;
            vecs[i].e_full  = 1'b1;
            vecs[i].e_afull = 1'b1;
            vecs[i].e_level = 5'd16;
            vecs[i].e_ovf   = 1'b1;
        end
        vecs[19].clr   = 1'b1;
        vecs[20].wen   = 1'b0;
        vecs[20].clr   = 1'b1;
        vecs[20].e_ovf = 1'b0;

        for (int i = 0; i < 22; i++) begin
            drive(vecs[i].rst_n, vecs[i].wen, vecs[i].clr, vecs[i].rptr);
            #3;
            chk($sformatf("v%0d accept", i), 32'(bus.WR_ACCEPT), 32'(vecs[i].e_acc));
            tick();
            chk($sformatf("v%0d addr", i), 32'(bus.W_ADDR_A), 32'(vecs[i].e_addr));
            chk($sformatf("v%0d gray", i), 32'(bus.W_PTR_GREY), 32'(vecs[i].e_gray));
            chk($sformatf("v%0d full", i), 32'(bus.FULL), 32'(vecs[i].e_full));
            chk($sformatf("v%0d afull", i), 32'(bus.ALMOST_FULL), 32'(vecs[i].e_afull));
            chk($sformatf("v%0d level", i), 32'(bus.W_LEVEL), 32'(vecs[i].e_level));
            chk($sformatf("v%0d ovf", i), 32'(bus.OVERFLOW), 32'(vecs[i].e_ovf));
        end

        // Drain: one read becomes visible three edges after it arrives.
        drive(1, 0, 0, 5'b00001);
        for (int e = 1; e <= 3; e++) begin
            tick();
            chk($sformatf("drain e%0d full", e), 32'(bus.FULL), (e < 3) ? 32'd1 : 32'd0);
            chk($sformatf("drain e%0d level", e), 32'(bus.W_LEVEL), (e < 3) ? 32'd16 : 32'd15);
            chk($sformatf("drain e%0d afull", e), 32'(bus.ALMOST_FULL), 32'd1);
        end

        // Reset mid-fill.
        drive(0, 0, 0, 5'd0);
        tick();
        tick();
        for (int k = 1; k <= 5; k++) begin
            drive(1, 1, 0, 5'd0);
            tick();
            chk($sformatf("mid k%0d level", k), 32'(bus.W_LEVEL), 32'(k));
        end
        drive(0, 1, 0, 5'd0);
        #3;
        chk("mid rst accept", 32'(bus.WR_ACCEPT), 32'd0);
        tick();
        chk("mid rst addr", 32'(bus.W_ADDR_A), 32'd0);
        chk("mid rst level", 32'(bus.W_LEVEL), 32'd0);
        chk("mid rst gray", 32'(bus.W_PTR_GREY), 32'd0);
        chk("mid rst ovf", 32'(bus.OVERFLOW), 32'd0);
        drive(1, 1, 0, 5'd0);
        tick();
        chk("restart addr", 32'(bus.W_ADDR_A), 32'd1);
        chk("restart gray", 32'(bus.W_PTR_GREY), 32'd1);

        // Wrap: 40 writes with the read pointer trailing, so the level settles at 5.
        drive(0, 0, 0, 5'd0);
        tick();
        wraps     = 0;
        prev_addr = bus.W_ADDR_A;
        prev_gray = bus.W_PTR_GREY;
        for (int k = 1; k <= 40; k++) begin
            rp_bin = (k >= 3) ? 32'(k - 3) : 32'd0;
            drive(1, 1, 0, g2(rp_bin));
            #3;
            chk($sformatf("wrap k%0d accept", k), 32'(bus.WR_ACCEPT), 32'd1);
            tick();
            chk($sformatf("wrap k%0d addr", k), 32'(bus.W_ADDR_A), 32'(k % 16));
            chk($sformatf("wrap k%0d 1bit", k), 32'($countones(bus.W_PTR_GREY ^ prev_gray)),
                32'd1);
            chk($sformatf("wrap k%0d msb", k), 32'(bus.W_PTR_GREY[4]), 32'((k >> 4) & 1));
            chk($sformatf("wrap k%0d full", k), 32'(bus.FULL), 32'd0);
            chk($sformatf("wrap k%0d level", k), 32'(bus.W_LEVEL), (k < 5) ? 32'(k) : 32'd5);
            if (prev_addr == 4'd15 && bus.W_ADDR_A == 4'd0) wraps++;
            prev_addr = bus.W_ADDR_A;
            prev_gray = bus.W_PTR_GREY;
        end
        chk("wrap count", 32'(wraps), 32'd2);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
